// File: rtl/systolic_input_skew.sv
// West-edge feeder for the systolic array: vector FIFO, per-lane skew
// lines and batch tracking with a done pulse.
module systolic_input_skew #(
  parameter int ROWS       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_switch,
  input  logic                       in_last,
  input  logic                       issue_en,
  output logic [ROWS*DATA_WIDTH-1:0] out_input,
  output logic [ROWS-1:0]            out_valid,
  output logic [ROWS-1:0]            out_switch,
  output logic                       busy,
  output logic                       done
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int VW   = ROWS * DATA_WIDTH;
  localparam int CNTW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  logic [VW-1:0]    r_mem_d [DEPTH];
  logic [DEPTH-1:0] r_mem_sw;
  logic [DEPTH-1:0] r_mem_last;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  state_t           r_state;
  logic [CNTW-1:0]  r_cnt;
  logic             r_done;

  logic             w_push;
  logic             w_pop;
  logic [VW-1:0]    w_rd_data;
  logic             w_rd_sw;
  logic             w_rd_last;

  // Full blocks the push even when a pop frees a slot on the same edge.
  assign in_ready  = (r_count < CW'(DEPTH));
  assign w_push    = in_valid && in_ready;
  assign w_pop     = issue_en && (r_count != '0);
  assign w_rd_data = r_mem_d[r_rd_ptr];
  assign w_rd_sw   = r_mem_sw[r_rd_ptr];
  assign w_rd_last = r_mem_last[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_d[i] <= '0;
      end
      r_mem_sw   <= '0;
      r_mem_last <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_mem_d[r_wr_ptr]    <= in_data;
        r_mem_sw[r_wr_ptr]   <= in_switch;
        r_mem_last[r_wr_ptr] <= in_last;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Lane r is an (r+1)-deep chain; stage r is the output register.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_d [r+1];
    logic [r:0]            r_v;
    logic [r:0]            r_s;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) begin
          r_d[k] <= '0;
        end
        r_v <= '0;
        r_s <= '0;
      end else begin
        r_d[0] <= w_pop ? w_rd_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        r_v[0] <= w_pop;
        r_s[0] <= w_pop && w_rd_sw;
        for (int k = 1; k <= r; k++) begin
          r_d[k] <= r_d[k-1];
          r_v[k] <= r_v[k-1];
          r_s[k] <= r_s[k-1];
        end
      end
    end

    assign out_input[r*DATA_WIDTH +: DATA_WIDTH] = r_d[r];
    assign out_valid[r]  = r_v[r];
    assign out_switch[r] = r_s[r];
  end

  // A pop always wins over draining: new batch cancels the pending done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        if (w_rd_last) begin
          r_state <= S_DRAIN;
          r_cnt   <= CNTW'(ROWS - 1);
        end else begin
          r_state <= S_STREAM;
        end
      end else begin
        unique case (r_state)
          S_DRAIN: begin
            if (r_cnt == '0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_systolic_input_skew.sv
// Bench for systolic_input_skew: queue-based model, per-lane scoreboards
// and a negedge monitor.
module tb_systolic_input_skew;

  localparam int ROWS  = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int VW    = ROWS * DW;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [VW-1:0]   in_data;
  logic            in_switch;
  logic            in_last;
  logic            issue_en;
  logic [VW-1:0]   out_input;
  logic [ROWS-1:0] out_valid;
  logic [ROWS-1:0] out_switch;
  logic            busy;
  logic            done;

  systolic_input_skew #(
    .ROWS(ROWS), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_switch(in_switch),
    .in_last(in_last), .issue_en(issue_en),
    .out_input(out_input), .out_valid(out_valid),
    .out_switch(out_switch), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] d;
    logic          sw;
    logic          last;
  } vec_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
    logic          sw;
  } lane_t;

  vec_t  fq[$];
  lane_t lq[ROWS][$];
  int    dq[$];
  int    pend;
  bit    busy_m;
  int    cyc;
  bit    mon_on;
  int    checks;
  int    failures;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic flush_model();
    fq.delete();
    for (int r = 0; r < ROWS; r++) lq[r].delete();
    dq.delete();
    pend   = -1;
    busy_m = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on the edge.
  task automatic step(input logic v, input logic [VW-1:0] d,
                      input logic sw, input logic lst, input logic ie);
    vec_t  e;
    lane_t l;
    bit    do_pop;
    bit    do_push;
    in_valid  = v;
    in_data   = d;
    in_switch = sw;
    in_last   = lst;
    issue_en  = ie;
    #1;
    chk("in_ready", in_ready, (fq.size() < DEPTH));
    @(posedge clk);
    cyc++;
    do_pop  = ie && (fq.size() > 0);
    do_push = v && (fq.size() < DEPTH);
    if (do_pop) begin
      e = fq.pop_front();
      for (int r = 0; r < ROWS; r++) begin
        l.cyc = cyc + r;
        l.d   = e.d[r*DW +: DW];
        l.sw  = e.sw;
        lq[r].push_back(l);
      end
      pend   = e.last ? cyc + ROWS : -1;
      busy_m = 1'b1;
    end else if (pend == cyc) begin
      dq.push_back(cyc);
      pend   = -1;
      busy_m = 1'b0;
    end
    if (do_push) begin
      e.d    = d;
      e.sw   = sw;
      e.last = lst;
      fq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    lane_t l;
    if (mon_on && rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        if (out_valid[r]) begin
          if (lq[r].size() == 0) begin
            chk($sformatf("lane%0d_unexpected", r), 1'b1, 1'b0);
          end else begin
            l = lq[r].pop_front();
            chk($sformatf("lane%0d_cycle", r), 64'(cyc), 64'(l.cyc));
            chk($sformatf("lane%0d_data", r), out_input[r*DW +: DW], l.d);
            chk($sformatf("lane%0d_switch", r), out_switch[r], l.sw);
          end
        end else begin
          chk($sformatf("lane%0d_bubble", r),
              {out_input[r*DW +: DW], out_switch[r]}, '0);
          if (lq[r].size() > 0 && lq[r][0].cyc < cyc) begin
            chk($sformatf("lane%0d_missing", r), 64'(cyc), 64'(lq[r][0].cyc));
            void'(lq[r].pop_front());
          end
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
        else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
      end else if (dq.size() > 0 && dq[0] < cyc) begin
        chk("done_missing", 64'(cyc), 64'(dq[0]));
        void'(dq.pop_front());
      end
      chk("busy", busy, busy_m);
    end
  end

  initial begin
    int e0;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    mon_on    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_switch = 1'b0;
    in_last   = 1'b0;
    issue_en  = 1'b0;
    flush_model();
    #7;
    chk("rst_outputs", {out_input, out_valid, out_switch, busy, done}, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    #5;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // single vector with explicit expectations
    step(1'b1, {16'h0200, 16'h0100}, 1'b1, 1'b1, 1'b1);
    e0 = cyc;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sv_lane0", out_input[15:0], 16'h0100);
    chk("sv_valid1", out_valid, 2'b01);
    chk("sv_switch1", out_switch, 2'b01);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sv_lane1", out_input[31:16], 16'h0200);
    chk("sv_valid2", out_valid, 2'b10);
    chk("sv_switch2", out_switch, 2'b10);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sv_done", done, 1'b1);
    chk("sv_done_at", 64'(cyc - e0), 64'd3);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sv_done_pulse", done, 1'b0);
    chk("sv_idle", busy, 1'b0);
    idle(2);

    // back-to-back A, B, C(last)
    step(1'b1, {16'h0A01, 16'h0A00}, 1'b1, 1'b0, 1'b1);
    step(1'b1, {16'h0B01, 16'h0B00}, 1'b0, 1'b0, 1'b1);
    step(1'b1, {16'h0C01, 16'h0C00}, 1'b0, 1'b1, 1'b1);
    idle(6);

    // backpressure: five pushes with issue held off
    for (int i = 0; i < 5; i++)
      step(1'b1, VW'(32'h1000_0000 + i), 1'b0, (i == 4), 1'b0);
    chk("bp_full", in_ready, 1'b0);
    step(1'b1, VW'(32'h1000_0004), 1'b0, 1'b1, 1'b1);
    step(1'b1, VW'(32'h1000_0004), 1'b0, 1'b1, 1'b1);
    idle(8);

    // bubble between A and B
    step(1'b1, {16'h2A01, 16'h2A00}, 1'b0, 1'b0, 1'b1);
    step(1'b1, {16'h2B01, 16'h2B00}, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // new batch arriving while draining
    step(1'b1, {16'h3001, 16'h3000}, 1'b0, 1'b1, 1'b1);
    step(1'b1, {16'h3101, 16'h3100}, 1'b1, 1'b0, 1'b1);
    step(1'b1, {16'h3201, 16'h3200}, 1'b0, 1'b1, 1'b1);
    idle(6);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), VW'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) < 7));
    idle(DEPTH + ROWS + 4);

    // reset with two queued entries and one in flight
    step(1'b1, VW'(32'h5555_4444), 1'b1, 1'b0, 1'b0);
    step(1'b1, VW'(32'h6666_7777), 1'b0, 1'b1, 1'b0);
    step(1'b1, VW'(32'h8888_9999), 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    flush_model();
    #1;
    chk("mid_rst_outputs", {out_input, out_valid, out_switch, busy, done}, '0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    step(1'b1, {16'h7701, 16'h7700}, 1'b1, 1'b1, 1'b1);
    idle(6);

    for (int r = 0; r < ROWS; r++)
      chk($sformatf("lane%0d_leftover", r), 64'(lq[r].size()), 64'd0);
    chk("done_leftover", 64'(dq.size()), 64'd0);
    chk("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
